split_tx_loader: RTL

Byte-serial front end for the split-transaction proof circuit. It assembles a 463-byte serialized split transaction into the 3704-bit `transaction` vector, framing-checks it, and holds the result for the split-delivery hashing stage downstream. It also rejects frames whose sighash-type field is wrong. The downstream stage sees a non-zero vector only while `out_valid` is high.

---
 rtl/split_tx_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/split_tx_loader.sv
// Byte-serial loader: assembles a fixed-length split transaction frame, checks
// length and sighash-type framing, and holds the frame until downstream consumes it.
module split_tx_loader #(
   parameter int          TX_BYTES       = 463,
   parameter logic [31:0] EXPECT_SIGHASH = 32'h01000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic [TX_BYTES*8-1:0]   transaction,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err,
   output logic [1:0]              err_code
);

   localparam int         W        = TX_BYTES * 8;
   localparam logic [8:0] LAST_IDX = 9'(TX_BYTES - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [8:0]    cnt_reg, cnt_next;
   logic          err_reg, err_next;
   logic [1:0]    err_code_reg, err_code_next;
   logic [W-1:0]  buf_reg;
   logic          wr_en;
   logic          accept;

   assign in_ready    = (state_reg != HOLD);
   assign out_valid   = (state_reg == HOLD);
   assign accept      = in_valid && in_ready;
   // Gating keeps stale or rejected buffer contents invisible downstream.
   assign transaction = out_valid ? buf_reg : '0;
   assign err         = err_reg;
   assign err_code    = err_code_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= LOAD;
         cnt_reg      <= '0;
         err_reg      <= 1'b0;
         err_code_reg <= 2'd0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         err_reg      <= err_next;
         err_code_reg <= err_code_next;
      end
   end

   // Byte k lands in the k-th byte lane counted from the MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_reg <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < TX_BYTES; i++) begin
            if (cnt_reg == 9'(i)) begin
               buf_reg[W-1-8*i -: 8] <= in_data;
            end
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      err_next      = 1'b0;
      err_code_next = err_code_reg;
      wr_en         = 1'b0;
      case (state_reg)
         LOAD: begin
            if (accept) begin
               wr_en = 1'b1;
               if (cnt_reg == LAST_IDX) begin
                  cnt_next = '0;
                  if (!in_last) begin
                     err_next      = 1'b1;
                     err_code_next = 2'd2;
                     state_next    = DRAIN;
                  end else if (buf_reg[871:840] != EXPECT_SIGHASH) begin
                     // Sighash bytes were stored on earlier cycles, so the
                     // buffer already holds them when the last byte arrives.
                     err_next      = 1'b1;
                     err_code_next = 2'd3;
                  end else begin
                     state_next = HOLD;
                  end
               end else if (in_last) begin
                  err_next      = 1'b1;
                  err_code_next = 2'd1;
                  cnt_next      = '0;
               end else begin
                  cnt_next = cnt_reg + 9'd1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = LOAD;
               cnt_next   = '0;
            end
         end
         DRAIN: begin
            if (accept && in_last) begin
               state_next = LOAD;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = LOAD;
            cnt_next   = '0;
         end
      endcase
   end

endmodule
